enc8b10b_lanes: RTL and testbench
=================================

Name: enc8b10b_lanes

Overview:
Registered, multi-lane 8b/10b encoder. It carries running disparity (RD) between cycles and chains it across lanes within a beat.
- Sits between the framing/idle-insertion logic and the serializer. Replaces the per-nibble combinational encoders with one streaming block.
- Uses valid/ready on both sides, K-character support and code-violation flagging.

Parameters:
LANES, 1, number of bytes encoded per beat (1..8); lane 0 occupies the low bits and is transmitted first.
RD_INIT, 0, running disparity after reset (0 = RD-, 1 = RD+).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat this cycle
in_data  input  8*LANES  bytes; lane n = bits [8n+7:8n], bit order HGFEDCBA
in_k  input  LANES  per-lane control (K) flag
out_valid  output  1  encoded beat valid
out_ready  input  1  downstream accepts beat
out_data  output  10*LANES  lane n = bits [10n+9:10n] = {a,b,c,d,e,i,f,g,h,j}, a at MSB
out_code_err  output  LANES  lane had K=1 with an illegal K code
rd_out  output  1  current running disparity (1 = RD+)

Behaviour:
- Reset (async assert, sync release) values: out_valid=0, out_data=0, out_code_err=0, rd register=RD_INIT, rd_out=RD_INIT.
- Single output register stage:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready; out_data, out_code_err and out_valid=1 update on that edge. Latency is 1 cycle.
- When out_valid && out_ready and no new acceptance occurs, out_valid clears next edge. out_data holds its last value.
- While out_valid && !out_ready, out_data and out_code_err stay stable and in_ready=0.
- RD chaining:
  - Lane 0 encodes with the rd register.
  - Lane n encodes with the RD produced by lane n-1.
  - The rd register takes lane LANES-1's output RD, only on acceptance.
- 5b/6b and 3b/4b tables are standard IEEE 802.3 clause 36. The sub-block RD for 3b/4b comes from the 6b sub-block result.
- Alternate D.x.7 (A7) is used when:
  - RD- and x in {17,18,20}, or
  - RD+ and x in {11,13,14}.
- Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
  - K28.y uses 001111/110000 6b with the K-specific 3b/4b.
  - Kx.7 uses 1000/0111.
- Illegal K on a lane: set out_code_err[n]=1 and encode that lane as D.x.y with the same byte. The RD chain proceeds normally.
- Balanced codes (including D.x.y where both sub-blocks are neutral) leave RD unchanged.
- Reset mid-stream discards the pending output and restores RD_INIT.

Optional Feature:
ENC8B10B_RD_LOAD_EN
- Defined: adds input ports rd_load (1) and rd_value (1).
  - rd_load=1 on a clock edge writes rd_value into the rd register.
  - If rd_load coincides with an accepted beat, the beat encodes with the old RD and rd_load wins for the register update.
  - Used for lane alignment and test.
- Undefined: ports absent; RD changes only through encoding and reset.

Decomposition:
- Package enc8b10b_pkg holds:
  - constants K28_5=8'hBC, K28_0..K28_7, K23_7, K27_7, K29_7, K30_7;
  - a function is_legal_k(byte);
  - a typedef for the 10-bit symbol.
- One combinational sub-module, enc8b10b_sym:
  - inputs: byte, k, rd_in;
  - outputs: sym[9:0], rd_out, code_err.
  - enc8b10b_lanes instantiates it LANES times in a chain and owns all state and handshake logic.

Test Plan:
- LANES=1, reset then two beats 0xBC K=1, out_ready=1 → out_data 0011111010 (rd_out=1), then 1100000101 (rd_out=0).
- 0xB5 D at RD- and at RD+ → 1010101010 both times, rd_out unchanged.
- From RD-: 0x03 D → 1100011011, rd_out=1; next 0x03 D → 1100010100, rd_out=0. 0x00 D from RD- → 1001110100, rd unchanged.
- LANES=2, beat {0x03,0x03} D from RD- → lane0 1100011011, lane1 1100010100, rd_out=0. A7: 0xF1 (D.17.7) from RD- → 1000110111.
- Backpressure:
  - Hold out_ready=0 with in_valid=1 for 5 cycles → in_ready=0, out_data stable, rd_out frozen.
  - Release → one beat per cycle, no loss or duplication versus the reference model.
- 0x00 with K=1 → out_code_err=1, out_data 1001110100. Assert rst_n low mid-stream → out_valid=0, rd_out=RD_INIT immediately.

Source files
------------

// File: rtl/enc8b10b_pkg.sv
// Shared K-code constants, the 10-bit symbol type and the K-code legality check
// for the 8b/10b lane encoder.
package enc8b10b_pkg;

    typedef logic [9:0] sym10_t;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    function automatic logic is_legal_k(input logic [7:0] b);
        return (b == K28_0) || (b == K28_1) || (b == K28_2) || (b == K28_3) ||
               (b == K28_4) || (b == K28_5) || (b == K28_6) || (b == K28_7) ||
               (b == K23_7) || (b == K27_7) || (b == K29_7) || (b == K30_7);
    endfunction

endpackage

// File: rtl/enc8b10b_sym.sv
// Combinational single-symbol 8b/10b encoder (IEEE 802.3 clause 36 tables).
// Illegal K bytes are flagged and encoded as the data character of the same byte.
module enc8b10b_sym
    import enc8b10b_pkg::*;
(
    input  logic [7:0] din,
    input  logic       k,
    input  logic       rd_in,
    output sym10_t     sym,
    output logic       rd_out,
    output logic       code_err
);

    logic [4:0] x;
    logic [2:0] y;
    logic       use_k;
    logic       k28;
    logic       a7;
    logic       rd_mid;
    logic       flip6;
    logic       flip4;
    logic [5:0] c6n;
    logic [3:0] c4n;

    assign x = din[4:0];
    assign y = din[7:5];

    // c6n/c4n hold the RD- form; RD+ is the complement for unbalanced codes
    // and for the balanced-but-alternating D.7 / D.x.3 / D.x.7 cases.
    always_comb begin
        use_k    = k && is_legal_k(din);
        code_err = k && !is_legal_k(din);
        k28      = use_k && (x == 5'd28);

        c6n = 6'b000000;
        case (x)
            5'd0:  c6n = 6'b100111;
            5'd1:  c6n = 6'b011101;
            5'd2:  c6n = 6'b101101;
            5'd3:  c6n = 6'b110001;
            5'd4:  c6n = 6'b110101;
            5'd5:  c6n = 6'b101001;
            5'd6:  c6n = 6'b011001;
            5'd7:  c6n = 6'b111000;
            5'd8:  c6n = 6'b111001;
            5'd9:  c6n = 6'b100101;
            5'd10: c6n = 6'b010101;
            5'd11: c6n = 6'b110100;
            5'd12: c6n = 6'b001101;
            5'd13: c6n = 6'b101100;
            5'd14: c6n = 6'b011100;
            5'd15: c6n = 6'b010111;
            5'd16: c6n = 6'b011011;
            5'd17: c6n = 6'b100011;
            5'd18: c6n = 6'b010011;
            5'd19: c6n = 6'b110010;
            5'd20: c6n = 6'b001011;
            5'd21: c6n = 6'b101010;
            5'd22: c6n = 6'b011010;
            5'd23: c6n = 6'b111010;
            5'd24: c6n = 6'b110011;
            5'd25: c6n = 6'b100110;
            5'd26: c6n = 6'b010110;
            5'd27: c6n = 6'b110110;
            5'd28: c6n = 6'b001110;
            5'd29: c6n = 6'b101110;
            5'd30: c6n = 6'b011110;
            5'd31: c6n = 6'b101011;
        endcase
        if (k28) c6n = 6'b001111;

        flip6  = ($countones(c6n) != 3) || (x == 5'd7);
        rd_mid = rd_in ^ ($countones(c6n) != 3);
        a7     = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));

        c4n = 4'b0000;
        if (k28) begin
            case (y)
                3'd0: c4n = 4'b1011;
                3'd1: c4n = 4'b0110;
                3'd2: c4n = 4'b1010;
                3'd3: c4n = 4'b1100;
                3'd4: c4n = 4'b1101;
                3'd5: c4n = 4'b0101;
                3'd6: c4n = 4'b1001;
                3'd7: c4n = 4'b0111;
            endcase
            flip4 = 1'b1;
        end else begin
            case (y)
                3'd0: c4n = 4'b1011;
                3'd1: c4n = 4'b1001;
                3'd2: c4n = 4'b0101;
                3'd3: c4n = 4'b1100;
                3'd4: c4n = 4'b1101;
                3'd5: c4n = 4'b1010;
                3'd6: c4n = 4'b0110;
                3'd7: c4n = 4'b1110;
            endcase
            if (y == 3'd7 && (a7 || use_k)) c4n = 4'b0111;
            flip4 = ($countones(c4n) != 2) || (y == 3'd3) || (y == 3'd7);
        end

        rd_out = rd_mid ^ ($countones(c4n) != 2);
        sym    = {(rd_in && flip6) ? ~c6n : c6n, (rd_mid && flip4) ? ~c4n : c4n};
    end

endmodule

// File: rtl/enc8b10b_lanes.sv
// Registered multi-lane 8b/10b encoder with valid/ready and RD chained across lanes.
// Optional ENC8B10B_RD_LOAD_EN adds rd_load/rd_value to force the running disparity.
module enc8b10b_lanes
    import enc8b10b_pkg::*;
#(
    parameter int LANES   = 1,
    parameter bit RD_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_code_err,
`ifdef ENC8B10B_RD_LOAD_EN
    input  logic                  rd_load,
    input  logic                  rd_value,
`endif
    output logic                  rd_out
);

    logic                  out_valid_q, out_valid_d;
    logic [10*LANES-1:0]   out_data_q, out_data_d;
    logic [LANES-1:0]      out_err_q, out_err_d;
    logic                  rd_q, rd_d;
    logic                  accept;
    logic [LANES:0]        rd_chain;
    logic [10*LANES-1:0]   sym_all;
    logic [LANES-1:0]      err_all;

    assign rd_chain[0] = rd_q;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        enc8b10b_sym u_sym (
            .din      (in_data[8*n +: 8]),
            .k        (in_k[n]),
            .rd_in    (rd_chain[n]),
            .sym      (sym_all[10*n +: 10]),
            .rd_out   (rd_chain[n+1]),
            .code_err (err_all[n])
        );
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_data_d  = accept ? sym_all : out_data_q;
        out_err_d   = accept ? err_all : out_err_q;
        rd_d        = accept ? rd_chain[LANES] : rd_q;
`ifdef ENC8B10B_RD_LOAD_EN
        // A load on the same edge as a beat wins; the beat already used the old RD.
        if (rd_load) rd_d = rd_value;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            rd_q        <= RD_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_code_err = out_err_q;
    assign rd_out       = rd_q;

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed-vector bench for enc8b10b_lanes: a 1-lane and a 2-lane instance.
module tb_enc8b10b_lanes;

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic [9:0] exp_sym;
        logic       exp_err;
        logic       exp_rd;
    } vec_t;

    localparam int NV = 14;

    logic        clk;
    logic        rst_n;

    logic        iv1, ir1, ov1, or1, rd1;
    logic [7:0]  id1;
    logic [0:0]  ik1, oe1;
    logic [9:0]  od1;

    logic        iv2, ir2, ov2, or2, rd2;
    logic [15:0] id2;
    logic [1:0]  ik2, oe2;
    logic [19:0] od2;

    int checks;
    int failures;
    vec_t vecs [NV];

    enc8b10b_lanes #(.LANES(1), .RD_INIT(1'b0)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv1),
        .in_ready     (ir1),
        .in_data      (id1),
        .in_k         (ik1),
        .out_valid    (ov1),
        .out_ready    (or1),
        .out_data     (od1),
        .out_code_err (oe1),
`ifdef ENC8B10B_RD_LOAD_EN
        .rd_load      (1'b0),
        .rd_value     (1'b0),
`endif
        .rd_out       (rd1)
    );

    enc8b10b_lanes #(.LANES(2), .RD_INIT(1'b0)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv2),
        .in_ready     (ir2),
        .in_data      (id2),
        .in_k         (ik2),
        .out_valid    (ov2),
        .out_ready    (or2),
        .out_data     (od2),
        .out_code_err (oe2),
`ifdef ENC8B10B_RD_LOAD_EN
        .rd_load      (1'b0),
        .rd_value     (1'b0),
`endif
        .rd_out       (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int idx_in;
        int idx_out;
        logic [9:0] held;
        logic [7:0] rdy_pat;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b1};
        vecs[1]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0};
        vecs[2]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0};
        vecs[3]  = '{8'h03, 1'b0, 10'b1100011011, 1'b0, 1'b1};
        vecs[4]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b1};
        vecs[5]  = '{8'h03, 1'b0, 10'b1100010100, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 1'b1, 10'b1001110100, 1'b1, 1'b0};
        vecs[8]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b0, 1'b1};
        vecs[9]  = '{8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0};
        vecs[10] = '{8'h3C, 1'b1, 10'b0011111001, 1'b0, 1'b1};
        vecs[11] = '{8'hF7, 1'b1, 10'b0001010111, 1'b0, 1'b1};
        vecs[12] = '{8'hE7, 1'b0, 10'b0001110001, 1'b0, 1'b0};
        vecs[13] = '{8'h63, 1'b0, 10'b1100011100, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv1 = 1'b0; id1 = 8'h00; ik1 = 1'b0; or1 = 1'b1;
        iv2 = 1'b0; id2 = 16'h0000; ik2 = 2'b00; or2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", ov1, 0);
        check("reset_out_data", od1, 0);
        check("reset_code_err", oe1, 0);
        check("reset_rd_out", rd1, 0);
        check("reset_in_ready", ir1, 1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            iv1 = 1'b1; id1 = vecs[i].data; ik1 = vecs[i].k; or1 = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), ov1, 1);
            check($sformatf("vec%0d_sym", i), od1, vecs[i].exp_sym);
            check($sformatf("vec%0d_err", i), oe1, vecs[i].exp_err);
            check($sformatf("vec%0d_rd", i), rd1, vecs[i].exp_rd);
        end

        // Backpressure: output stalled with a new beat offered.
        held = vecs[NV-1].exp_sym;
        iv1 = 1'b1; id1 = 8'hBC; ik1 = 1'b1; or1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), ir1, 0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_data", c), od1, held);
            check($sformatf("stall%0d_valid", c), ov1, 1);
            check($sformatf("stall%0d_rd", c), rd1, vecs[NV-1].exp_rd);
        end

        // Reset mid-stream with a pending output.
        rst_n = 1'b0;
        #1;
        check("midreset_valid", ov1, 0);
        check("midreset_rd", rd1, 0);
        check("midreset_data", od1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with irregular out_ready; output must match the vector list in order.
        idx_in  = 0;
        idx_out = 0;
        rdy_pat = 8'b1011_0110;
        for (int cyc = 0; cyc < 100 && idx_out < NV; cyc++) begin
            or1 = rdy_pat[cyc % 8];
            iv1 = (idx_in < NV);
            if (idx_in < NV) begin
                id1 = vecs[idx_in].data;
                ik1 = vecs[idx_in].k;
            end
            #1;
            if (ov1 && or1) begin
                check($sformatf("stream%0d_sym", idx_out), {oe1, od1},
                      {vecs[idx_out].exp_err, vecs[idx_out].exp_sym});
                idx_out++;
            end
            if (iv1 && ir1) idx_in++;
            @(posedge clk);
            #1;
        end
        check("stream_count", idx_out, NV);
        iv1 = 1'b0; or1 = 1'b1;
        @(posedge clk);
        #1;
        check("stream_drain_valid", ov1, 0);
        check("stream_end_rd", rd1, vecs[NV-1].exp_rd);

        // Two-lane chaining.
        iv2 = 1'b1; id2 = 16'h0303; ik2 = 2'b00; or2 = 1'b1;
        @(posedge clk);
        #1;
        check("l2_b0_data", od2, {10'b1100010100, 10'b1100011011});
        check("l2_b0_rd", rd2, 0);
        id2 = 16'hBCF1; ik2 = 2'b10;
        @(posedge clk);
        #1;
        check("l2_b1_data", od2, {10'b1100000101, 10'b1000110111});
        check("l2_b1_err", oe2, 0);
        check("l2_b1_rd", rd2, 0);
        iv2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
